// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - pipelined chunked ripple-carry adder/subtractor with valid/ready, optional PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             carry_out
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
        $error("WIDTH must be an exact multiple of CHUNK");
    end

    // Level 0 is the operand capture register; level k+1 is the output of adder stage k.
    logic [WIDTH-1:0] a_q [0:STAGES-1];
    logic [WIDTH-1:0] b_q [0:STAGES-1];
    logic [WIDTH-1:0] s_q [1:STAGES];
    logic             c_q [0:STAGES];
    logic             v_q [0:STAGES];
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    logic             ov_q;
`endif

    // Global stall: every register moves together, bubbles included.
    logic advance;
    assign advance   = !v_q[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES];
    assign sum       = s_q[STAGES];
    assign carry_out = c_q[STAGES];
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    assign overflow  = ov_q;
`endif

    // Capture operands, folding the subtract inversion into B up front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q[0] <= '0;
            b_q[0] <= '0;
            c_q[0] <= 1'b0;
            v_q[0] <= 1'b0;
        end else if (advance) begin
            a_q[0] <= a;
            b_q[0] <= sub ? ~b : b;
            c_q[0] <= carry_in;
            v_q[0] <= in_valid && in_ready;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
        logic             cmsb_d;
`endif

        if (k == 0) begin : g_first
            assign s_in = '0;
        end else begin : g_next
            assign s_in = s_q[k];
        end

        // Ripple chunk k; lower chunks already computed pass straight through.
        always_comb begin
            logic c_r;
            s_d = s_in;
            c_r = c_q[k];
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
            cmsb_d = 1'b0;
`endif
            for (int j = 0; j < CHUNK; j++) begin
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
                if (j == CHUNK - 1) cmsb_d = c_r;
`endif
                s_d[k*CHUNK+j] = a_q[k][k*CHUNK+j] ^ b_q[k][k*CHUNK+j] ^ c_r;
                c_r = (a_q[k][k*CHUNK+j] & b_q[k][k*CHUNK+j]) |
                      (c_r & (a_q[k][k*CHUNK+j] ^ b_q[k][k*CHUNK+j]));
            end
            c_d = c_r;
        end

        // Register partial sum, carry and valid for the next stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q[k+1] <= '0;
                c_q[k+1] <= 1'b0;
                v_q[k+1] <= 1'b0;
            end else if (advance) begin
                s_q[k+1] <= s_d;
                c_q[k+1] <= c_d;
                v_q[k+1] <= v_q[k];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Carry the operands forward so upper chunks arrive skewed by k cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q[k+1] <= '0;
                    b_q[k+1] <= '0;
                end else if (advance) begin
                    a_q[k+1] <= a_q[k];
                    b_q[k+1] <= b_q[k];
                end
            end
        end

`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                end else if (advance) begin
                    ov_q <= cmsb_d ^ c_d;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - scoreboard bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        carry_out;
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;
    exp_t sb[$];

    pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare every result the consumer actually takes.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {16'h0, sum}, 32'hdead_beef);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", {16'h0, sum}, {16'h0, e.s});
                chk("carry_out", {31'h0, carry_out}, {31'h0, e.c});
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
                chk("overflow", {31'h0, overflow}, {31'h0, e.o});
`endif
                if (e.lat) chk("latency", cyc - e.acc, 32'd4);
            end
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                         input logic tsub, input logic [15:0] es, input logic ec,
                         input logic eo, input bit lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a = ta; b = tb_v; carry_in = tci; sub = tsub; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_sum", {16'h0, sum}, 32'd0);
        chk("rst_carry_out", {31'h0, carry_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // 1. carry into chunk 2, exact latency
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        idle(); drain();
        // 2. carry through every stage
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        idle(); drain();
        // 3. subtract
        issue(16'h1234, 16'h0235, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b1);
        issue(16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        idle(); drain();

        // 4. back-to-back, a = 0x1001*i, b = 0xF0F0
        issue(16'h1001, 16'hF0F0, 1'b0, 1'b0, 16'h00F1, 1'b1, 1'b0, 1'b1);
        issue(16'h2002, 16'hF0F0, 1'b0, 1'b0, 16'h10F2, 1'b1, 1'b0, 1'b1);
        issue(16'h3003, 16'hF0F0, 1'b0, 1'b0, 16'h20F3, 1'b1, 1'b0, 1'b1);
        issue(16'h4004, 16'hF0F0, 1'b0, 1'b0, 16'h30F4, 1'b1, 1'b0, 1'b1);
        issue(16'h5005, 16'hF0F0, 1'b0, 1'b0, 16'h40F5, 1'b1, 1'b0, 1'b1);
        issue(16'h6006, 16'hF0F0, 1'b0, 1'b0, 16'h50F6, 1'b1, 1'b0, 1'b1);
        idle(); drain();

        // 5. backpressure: five beats fill the pipe, then a 5-cycle stall
        @(negedge clk);
        out_ready = 1'b0;
        issue(16'h1111, 16'h0001, 1'b0, 1'b0, 16'h1112, 1'b0, 1'b0, 1'b0);
        issue(16'h2222, 16'h0001, 1'b0, 1'b0, 16'h2223, 1'b0, 1'b0, 1'b0);
        issue(16'h3333, 16'h0001, 1'b0, 1'b0, 16'h3334, 1'b0, 1'b0, 1'b0);
        issue(16'h4444, 16'h0001, 1'b0, 1'b0, 16'h4445, 1'b0, 1'b0, 1'b0);
        issue(16'h5555, 16'h0001, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
            chk("stall_sum", {16'h0, sum}, 32'h1112);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // 6. reset with three beats in flight, first one already at the output
        out_ready = 1'b0;
        issue(16'h0101, 16'h0101, 1'b0, 1'b0, 16'h0202, 1'b0, 1'b0, 1'b0);
        issue(16'h0202, 16'h0202, 1'b0, 1'b0, 16'h0404, 1'b0, 1'b0, 1'b0);
        issue(16'h0303, 16'h0303, 1'b0, 1'b0, 16'h0606, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre_reset_valid", {31'h0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset_sum", {16'h0, sum}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("no_stale_output", {31'h0, out_valid}, 32'd0);
        end

        // signed overflow boundaries
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        idle(); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
